led_matrix_scan: RTL and testbench

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

---
 rtl/snake_pkg.sv | 24 ++
 rtl/led_shift_tx.sv | 113 +++++++++++
 rtl/led_matrix_scan.sv | 237 +++++++++++++++++++++++
 tb/tb_led_matrix_scan.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared matrix geometry, row type and scan state encoding
// Purpose: common definitions for the LED matrix scan path and the decoder/display path.
// Contents: MATRIX_N, ROW_W, row_t, scan_state_t, cnt_width().
package snake_pkg;

   localparam int MATRIX_N = 16;
   localparam int ROW_W    = $clog2(MATRIX_N);

   typedef logic [MATRIX_N-1:0] row_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_SHOW
   } scan_state_t;

   // Width of a counter that runs 0 .. max_val-1; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/led_shift_tx.sv
// rtl/led_shift_tx.sv - column serializer for the shift-register chain
// Purpose: shifts one row out MSB (column 15) first, each bit held for 2*CLK_DIV clk
//          cycles with ser_clk low for the first half and high for the second half.
// Ports:   clk, rst_n   - clock, synchronous active-low reset
//          start, data  - load data and begin shifting (ignored while abort is high)
//          abort        - drop everything and park ser_clk/ser_data low next cycle
//          busy         - high from the cycle after start until the last bit completes
//          done         - combinational, high on the final busy cycle
//          ser_data, ser_clk - serial outputs
module led_shift_tx
   import snake_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  row_t data,
   output logic busy,
   output logic done,
   output logic ser_data,
   output logic ser_clk
);

   localparam int                 DIV_W    = cnt_width(CLK_DIV);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [ROW_W-1:0]   BIT_LAST = ROW_W'(MATRIX_N - 1);

   logic             busy_q,     busy_d;
   logic             phase_q,    phase_d;
   logic [DIV_W-1:0] div_q,      div_d;
   logic [ROW_W-1:0] bit_q,      bit_d;
   row_t             shreg_q,    shreg_d;
   logic             ser_data_q, ser_data_d;
   logic             ser_clk_q,  ser_clk_d;

   always_comb begin
      busy_d     = busy_q;
      phase_d    = phase_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      ser_data_d = ser_data_q;
      ser_clk_d  = ser_clk_q;
      done       = 1'b0;

      if (abort) begin
         busy_d     = 1'b0;
         phase_d    = 1'b0;
         div_d      = '0;
         bit_d      = '0;
         ser_data_d = 1'b0;
         ser_clk_d  = 1'b0;
      end else if (start) begin
         busy_d     = 1'b1;
         phase_d    = 1'b0;
         div_d      = '0;
         bit_d      = '0;
         shreg_d    = data;
         ser_data_d = data[MATRIX_N-1];
         ser_clk_d  = 1'b0;
      end else if (busy_q) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!phase_q) begin
               phase_d   = 1'b1;
               ser_clk_d = 1'b1;
            end else begin
               phase_d   = 1'b0;
               ser_clk_d = 1'b0;
               if (bit_q == BIT_LAST) begin
                  busy_d     = 1'b0;
                  ser_data_d = 1'b0;
                  done       = 1'b1;
               end else begin
                  bit_d      = bit_q + 1'b1;
                  // shreg_q[MSB] is the bit on the wire; the next one sits just below it.
                  ser_data_d = shreg_q[MATRIX_N-2];
                  shreg_d    = {shreg_q[MATRIX_N-2:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         phase_q    <= 1'b0;
         div_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         ser_data_q <= 1'b0;
         ser_clk_q  <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         phase_q    <= phase_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         ser_data_q <= ser_data_d;
         ser_clk_q  <= ser_clk_d;
      end
   end

   assign busy     = busy_q;
   assign ser_data = ser_data_q;
   assign ser_clk  = ser_clk_q;

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - 16x16 LED matrix row scanner with tear-free double buffering
// Purpose: captures frames into a shadow buffer, swaps to the active buffer only when
//          row 0 starts, and scans rows SHIFT -> BLANK -> LATCH -> SHOW.
// Ports:   clk, rst_n        - clock, synchronous active-low reset
//          en                - scan enable; low parks outputs dark within one cycle
//          frame_valid, y1..y16 - one-cycle frame strobe and row data (bit i = column i)
//          row_sel           - row currently driven
//          ser_data, ser_clk, ser_latch, oe_n - shift-register chain controls
//          frame_done        - pulse on the last SHOW cycle of row 15
module led_matrix_scan
   import snake_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int ROW_HOLD = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                frame_valid,
   input  logic [MATRIX_N-1:0] y1,
   input  logic [MATRIX_N-1:0] y2,
   input  logic [MATRIX_N-1:0] y3,
   input  logic [MATRIX_N-1:0] y4,
   input  logic [MATRIX_N-1:0] y5,
   input  logic [MATRIX_N-1:0] y6,
   input  logic [MATRIX_N-1:0] y7,
   input  logic [MATRIX_N-1:0] y8,
   input  logic [MATRIX_N-1:0] y9,
   input  logic [MATRIX_N-1:0] y10,
   input  logic [MATRIX_N-1:0] y11,
   input  logic [MATRIX_N-1:0] y12,
   input  logic [MATRIX_N-1:0] y13,
   input  logic [MATRIX_N-1:0] y14,
   input  logic [MATRIX_N-1:0] y15,
   input  logic [MATRIX_N-1:0] y16,
   output logic [ROW_W-1:0]    row_sel,
   output logic                ser_data,
   output logic                ser_clk,
   output logic                ser_latch,
   output logic                oe_n,
   output logic                frame_done
);

   localparam int               CNT_MAX    = (ROW_HOLD > CLK_DIV) ? ROW_HOLD : CLK_DIV;
   localparam int               CNT_W      = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ROW_HOLD - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(MATRIX_N - 1);

   row_t y_arr [MATRIX_N];

   assign y_arr[0]  = y1;
   assign y_arr[1]  = y2;
   assign y_arr[2]  = y3;
   assign y_arr[3]  = y4;
   assign y_arr[4]  = y5;
   assign y_arr[5]  = y6;
   assign y_arr[6]  = y7;
   assign y_arr[7]  = y8;
   assign y_arr[8]  = y9;
   assign y_arr[9]  = y10;
   assign y_arr[10] = y11;
   assign y_arr[11] = y12;
   assign y_arr[12] = y13;
   assign y_arr[13] = y14;
   assign y_arr[14] = y15;
   assign y_arr[15] = y16;

   scan_state_t      state_q,      state_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic [ROW_W-1:0] row_q,        row_d;
   logic [ROW_W-1:0] row_sel_q,    row_sel_d;
   logic             oe_n_q,       oe_n_d;
   logic             ser_latch_q,  ser_latch_d;
   logic             frame_done_q, frame_done_d;
   logic             pending_q,    pending_d;
   row_t             shadow_q [MATRIX_N];
   row_t             shadow_d [MATRIX_N];
   row_t             active_q [MATRIX_N];
   row_t             active_d [MATRIX_N];

   logic tx_start;
   logic tx_busy;
   logic tx_done;
   row_t tx_data;
   logic swap;

   // Scan FSM: next state, row bookkeeping and serializer kick-off.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      row_sel_d = row_sel_q;
      tx_start  = 1'b0;
      swap      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d  = ST_SHIFT;
               row_d    = '0;
               tx_start = 1'b1;
               swap     = 1'b1;
            end
         end
         ST_SHIFT: begin
            // !tx_busy only matters if the serializer was somehow idle on entry.
            if (tx_done || !tx_busy) begin
               state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            state_d   = ST_LATCH;
            cnt_d     = '0;
            row_sel_d = row_q;
         end
         ST_LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHOW: begin
            if (cnt_q == HOLD_LAST) begin
               state_d  = ST_SHIFT;
               row_d    = row_q + 1'b1;
               tx_start = 1'b1;
               swap     = (row_q == ROW_LAST);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!en) begin
         state_d   = ST_IDLE;
         cnt_d     = cnt_q;
         row_d     = row_q;
         row_sel_d = row_sel_q;
         tx_start  = 1'b0;
         swap      = 1'b0;
      end
   end

   // The serializer captures its row on the same edge the buffers swap, so on a
   // swap it is fed the value the active buffer is about to take.
   always_comb begin
      if (swap) begin
         tx_data = frame_valid ? y_arr[0] : shadow_q[0];
      end else begin
         tx_data = active_q[row_d];
      end
   end

   // Double buffer: frames always land in shadow; active only changes at row 0.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (swap) begin
         if (frame_valid) begin
            active_d = y_arr;
            shadow_d = y_arr;
         end else begin
            active_d = shadow_q;
         end
         pending_d = 1'b0;
      end else if (frame_valid) begin
         shadow_d  = y_arr;
         pending_d = 1'b1;
      end
   end

   // Registered outputs decoded from the upcoming state so they line up with it.
   always_comb begin
      case (state_d)
         ST_SHOW:  oe_n_d = 1'b0;
         ST_SHIFT: oe_n_d = oe_n_q;
         default:  oe_n_d = 1'b1;
      endcase
      ser_latch_d  = (state_d == ST_LATCH);
      frame_done_d = (state_d == ST_SHOW) && (cnt_d == HOLD_LAST) && (row_d == ROW_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         row_q        <= '0;
         row_sel_q    <= '0;
         oe_n_q       <= 1'b1;
         ser_latch_q  <= 1'b0;
         frame_done_q <= 1'b0;
         pending_q    <= 1'b0;
         for (int i = 0; i < MATRIX_N; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         row_sel_q    <= row_sel_d;
         oe_n_q       <= oe_n_d;
         ser_latch_q  <= ser_latch_d;
         frame_done_q <= frame_done_d;
         pending_q    <= pending_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
      end
   end

   led_shift_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_shift_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (tx_start),
      .abort    (~en),
      .data     (tx_data),
      .busy     (tx_busy),
      .done     (tx_done),
      .ser_data (ser_data),
      .ser_clk  (ser_clk)
   );

   assign row_sel    = row_sel_q;
   assign oe_n       = oe_n_q;
   assign ser_latch  = ser_latch_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - self-checking bench for led_matrix_scan
module tb_led_matrix_scan;

   localparam int CD = 4;
   localparam int RH = 100;
   localparam int P  = 33 * CD + 1 + RH;
   localparam int F  = 16 * P;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        frame_valid = 1'b0;
   logic [15:0] y [16];
   logic [3:0]  row_sel;
   logic        ser_data, ser_clk, ser_latch, oe_n, frame_done;

   int   cyc = 0;
   int   tests = 0;
   int   failed = 0;
   logic mon_clr = 1'b0;

   int          ev_edge [$];
   int          ev_row  [$];
   logic [15:0] ev_data [$];
   int          ev_bits [$];
   int          ev_w    [$];
   int          fd_edge [$];

   int           fr_edge [$];
   logic [255:0] fr_bits [$];

   led_matrix_scan #(.CLK_DIV(CD), .ROW_HOLD(RH)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .frame_valid(frame_valid),
      .y1(y[0]), .y2(y[1]), .y3(y[2]), .y4(y[3]), .y5(y[4]), .y6(y[5]), .y7(y[6]), .y8(y[7]),
      .y9(y[8]), .y10(y[9]), .y11(y[10]), .y12(y[11]), .y13(y[12]), .y14(y[13]), .y15(y[14]), .y16(y[15]),
      .row_sel(row_sel), .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
      .oe_n(oe_n), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Chain model: shift on ser_clk rise, record the row on each latch pulse.
   initial begin
      logic        psclk;
      logic        plat;
      logic [15:0] sh;
      int          bits;
      int          w;
      psclk = 1'b0; plat = 1'b0; sh = '0; bits = 0; w = 0;
      forever begin
         @(negedge clk);
         if (mon_clr) begin
            ev_edge.delete(); ev_row.delete(); ev_data.delete();
            ev_bits.delete(); ev_w.delete(); fd_edge.delete();
            bits = 0; w = 0;
         end else begin
            if (ser_clk === 1'b1 && psclk === 1'b0) begin
               sh = {sh[14:0], ser_data};
               bits++;
            end
            if (ser_latch === 1'b1 && plat !== 1'b1) begin
               ev_edge.push_back(cyc);
               ev_row.push_back(int'(row_sel));
               ev_data.push_back(sh);
               ev_bits.push_back(bits);
               bits = 0;
               w = 0;
            end
            if (ser_latch === 1'b1) w++;
            if (ser_latch !== 1'b1 && plat === 1'b1) ev_w.push_back(w);
            if (frame_done === 1'b1) fd_edge.push_back(cyc);
         end
         psclk = ser_clk;
         plat  = ser_latch;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame shown by a scan is the newest frame_valid sampled at or before its row-0 edge.
   function automatic logic [15:0] frame_row(input int e, input int r);
      logic [255:0] f;
      f = '0;
      for (int k = 0; k < fr_edge.size(); k++) begin
         if (fr_edge[k] <= e) f = fr_bits[k];
      end
      return f[r*16 +: 16];
   endfunction

   task automatic send_frame(input logic [255:0] f);
      for (int i = 0; i < 16; i++) y[i] = f[i*16 +: 16];
      frame_valid = 1'b1;
      fr_edge.push_back(cyc + 1);
      fr_bits.push_back(f);
      step();
      frame_valid = 1'b0;
   endtask

   task automatic send_frame_at(input int e, input logic [255:0] f);
      wait_cyc(e - 1);
      send_frame(f);
   endtask

   function automatic logic [255:0] rand_frame();
      logic [255:0] f;
      for (int i = 0; i < 16; i++) f[i*16 +: 16] = 16'($urandom);
      return f;
   endfunction

   task automatic check_scan(input int base, input int n_ev, input string tag);
      chk({tag, "_count"}, ev_edge.size(), n_ev);
      for (int i = 0; i < n_ev && i < ev_edge.size(); i++) begin
         chk($sformatf("%s_%0d_sel", tag, i), ev_row[i], i % 16);
         chk($sformatf("%s_%0d_data", tag, i), 32'(ev_data[i]), 32'(frame_row(base + (i / 16) * F, i % 16)));
         chk($sformatf("%s_%0d_bits", tag, i), ev_bits[i], 16);
         chk($sformatf("%s_%0d_width", tag, i), (i < ev_w.size()) ? ev_w[i] : 0, CD);
         chk($sformatf("%s_%0d_edge", tag, i), ev_edge[i], base + i * P + 32 * CD + 1);
      end
   endtask

   initial begin
      logic [255:0] f;
      int s0, s1, s2, r5, lt, n;

      for (int i = 0; i < 16; i++) y[i] = '0;
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_row_sel", 32'(row_sel), 0);
      chk("rst_ser_data", 32'(ser_data), 0);
      chk("rst_ser_clk", 32'(ser_clk), 0);
      chk("rst_ser_latch", 32'(ser_latch), 0);
      chk("rst_oe_n", 32'(oe_n), 1);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_pending", 32'(dut.pending_q), 0);

      rst_n = 1'b1;
      step();
      f = '0;
      f[15:0] = 16'h8001;
      send_frame(f);
      chk("pending_set", 32'(dut.pending_q), 1);
      step();

      en = 1'b1;
      s0 = cyc + 1;
      step();
      chk("pending_swap", 32'(dut.pending_q), 0);
      chk("oe_first_shift", 32'(oe_n), 1);

      wait_cyc(s0 + 32 * CD);
      chk("blank_latch", 32'(ser_latch), 0);
      chk("blank_oe", 32'(oe_n), 1);
      chk("blank_sclk", 32'(ser_clk), 0);
      step();
      chk("latch_start", 32'(ser_latch), 1);
      chk("latch_row_sel", 32'(row_sel), 0);
      n = 0;
      while (ser_latch === 1'b1 && n < 1000) begin n++; step(); end
      chk("latch_len", n, CD);
      n = 0;
      while (oe_n === 1'b0 && row_sel === 4'd0 && n < 5000) begin n++; step(); end
      chk("row0_lit_len", n, 32 * CD + RH);
      chk("row0_lit_end", cyc, s0 + P + 32 * CD);

      send_frame_at(s0 + 3 * P + 50, rand_frame());
      send_frame_at(s0 + F + 7 * P + 10, rand_frame());
      chk("pending_mid", 32'(dut.pending_q), 1);
      send_frame_at(s0 + 3 * F, rand_frame());
      chk("pending_same_cycle", 32'(dut.pending_q), 0);

      r5 = s0 + 4 * F + 5 * P;
      wait_cyc(r5 + 20);
      en = 1'b0;
      step();
      chk("drop_oe", 32'(oe_n), 1);
      chk("drop_sclk", 32'(ser_clk), 0);
      chk("drop_latch", 32'(ser_latch), 0);
      chk("drop_row_sel", 32'(row_sel), 4);
      repeat (10) step();
      chk("idle_row_sel", 32'(row_sel), 4);
      chk("idle_oe", 32'(oe_n), 1);

      check_scan(s0, 69, "scan_a");
      chk("fd_count_a", fd_edge.size(), 4);
      for (int k = 0; k < 4 && k < fd_edge.size(); k++)
         chk($sformatf("fd_a_%0d", k), fd_edge[k], s0 + F - 1 + k * F);

      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
      en = 1'b1;
      s1 = cyc + 1;
      wait_cyc(s1 + F + 5);
      check_scan(s1, 16, "scan_b");
      chk("fd_count_b", fd_edge.size(), 1);
      if (fd_edge.size() > 0) chk("fd_b_0", fd_edge[0], s1 + F - 1);

      lt = s1 + F + 2 * P + 32 * CD + 1;
      wait_cyc(lt + 1);
      chk("pre_rst_latch", 32'(ser_latch), 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_latch", 32'(ser_latch), 0);
      chk("mid_rst_oe", 32'(oe_n), 1);
      chk("mid_rst_row_sel", 32'(row_sel), 0);
      chk("mid_rst_sclk", 32'(ser_clk), 0);
      chk("mid_rst_pending", 32'(dut.pending_q), 0);
      rst_n = 1'b1;
      fr_edge.delete();
      fr_bits.delete();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
      s2 = cyc;
      wait_cyc(s2 + F + 5);
      check_scan(s2, 16, "scan_zero");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
